// File: rtl/accel_sequencer_pkg.sv
// Shared constants for the accelerator control sequencer: array geometry,
// FSM state encoding, output mode codes and the registered strobe bundle.
package accel_sequencer_pkg;

    localparam int ARRAY_WIDTH = 4;
    localparam int ARRAY_LAT = 3 * ARRAY_WIDTH - 1;
    localparam int KW        = 8;
    localparam int CNT_W     = $clog2(ARRAY_LAT + ARRAY_WIDTH + 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CLR    = 4'd1;
    localparam logic [3:0] S_LOAD_W = 4'd2;
    localparam logic [3:0] S_PRE_W  = 4'd3;
    localparam logic [3:0] S_LOAD_A = 4'd4;
    localparam logic [3:0] S_STREAM = 4'd5;
    localparam logic [3:0] S_ACC    = 4'd6;
    localparam logic [3:0] S_DRAIN  = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    localparam logic [1:0] MODE_RAW     = 2'b00;
    localparam logic [1:0] MODE_RELU    = 2'b01;
    localparam logic [1:0] MODE_SOFTMAX = 2'b10;

    // Every Moore strobe, registered as one bundle from the next-state decode.
    typedef struct packed {
        logic host_ready;
        logic host_sel_weight;
        logic input_buffer_out_en;
        logic input_buffer_delay_clear;
        logic weight_buffer_out_en;
        logic write_weight_en;
        logic output_buffer_load_en;
        logic output_buffer_load_clear;
        logic output_buffer_acc_enable;
        logic output_buffer_acc_clear;
        logic output_buffer_out_en;
        logic relu_en;
        logic softmax_en;
        logic out_valid;
        logic busy;
        logic done;
    } strobe_t;

endpackage

// File: rtl/accel_sequencer_seq_beat_counter.sv
// Up-counter with synchronous clear and a terminal-count flag; exposes the
// next value so the owner can decode registered outputs one cycle early.
module accel_sequencer_seq_beat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] terminal,
    output logic [W-1:0] count_next,
    output logic         at_terminal
);

    logic [W-1:0] count;

    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (inc) begin
            count_next = count + W'(1);
        end
    end

    assign at_terminal = (count == terminal);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/accel_sequencer.sv
// Job sequencer for the systolic accelerator: load weights/activations per tile,
// preload, stream, accumulate K tiles, then drain with the latched output mode.
module accel_sequencer
    import accel_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [KW-1:0] k_tiles,
    input  logic [1:0]    mode,
    input  logic          host_valid,
    output logic          host_ready,
    output logic          host_sel_weight,
    output logic          input_buffer_load_en,
    output logic          input_buffer_out_en,
    output logic          input_buffer_delay_clear,
    output logic          weight_buffer_load_en,
    output logic          weight_buffer_out_en,
    output logic          write_weight_en,
    output logic          output_buffer_load_en,
    output logic          output_buffer_load_clear,
    output logic          output_buffer_acc_enable,
    output logic          output_buffer_acc_clear,
    output logic          output_buffer_out_en,
    output logic          relu_en,
    output logic          softmax_en,
    output logic          out_valid,
    output logic          busy,
    output logic          done,
    output logic [3:0]    fsm_state
);

    // Host handshake: a beat transfers in any cycle where host_ready and
    // host_valid are both high; host_ready depends only on state, never on
    // host_valid, and a low host_valid simply holds the beat count.

    logic [3:0]       state;
    logic [3:0]       state_d;
    logic [KW-1:0]    k_eff;
    logic [1:0]       mode_q;
    logic             beat;

    logic             cnt_clear;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt_term;
    logic [CNT_W-1:0] cnt_next;
    logic             cnt_last;

    logic             t_clear;
    logic             t_inc;
    logic [KW-1:0]    t_next;
    logic             t_last;

    strobe_t          strb;
    strobe_t          strb_d;

    assign beat = host_valid && ((state == S_LOAD_W) || (state == S_LOAD_A));

    always_comb begin
        state_d = state;
        if ((state != S_IDLE) && abort) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start) state_d = S_CLR;
                S_CLR:    state_d = S_LOAD_W;
                S_LOAD_W: if (beat && cnt_last) state_d = S_PRE_W;
                S_PRE_W:  if (cnt_last) state_d = S_LOAD_A;
                S_LOAD_A: if (beat && cnt_last) state_d = S_STREAM;
                S_STREAM: if (cnt_last) state_d = S_ACC;
                S_ACC:    state_d = t_last ? S_DRAIN : S_CLR;
                S_DRAIN:  if (cnt_last) state_d = S_DONE;
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Beat counter restarts on every state change; STREAM runs the longest.
    assign cnt_clear = (state_d != state);
    assign cnt_inc   = beat || (state == S_PRE_W) || (state == S_STREAM)
                       || (state == S_DRAIN);
    assign cnt_term  = (state == S_STREAM) ? CNT_W'(ARRAY_LAT + ARRAY_WIDTH - 1)
                                           : CNT_W'(ARRAY_WIDTH - 1);

    accel_sequencer_seq_beat_counter #(.W(CNT_W)) u_beat_cnt (
        .clk         (clk),
        .rst         (rst),
        .clear       (cnt_clear),
        .inc         (cnt_inc),
        .terminal    (cnt_term),
        .count_next  (cnt_next),
        .at_terminal (cnt_last)
    );

    // Tile counter: t_last means the tile now in ACC is the final one.
    assign t_clear = (state == S_IDLE) && start;
    assign t_inc   = (state == S_ACC);

    accel_sequencer_seq_beat_counter #(.W(KW)) u_tile_cnt (
        .clk         (clk),
        .rst         (rst),
        .clear       (t_clear),
        .inc         (t_inc),
        .terminal    (k_eff - KW'(1)),
        .count_next  (t_next),
        .at_terminal (t_last)
    );

    always_comb begin
        strb_d = '0;
        strb_d.busy = (state_d != S_IDLE);
        case (state_d)
            S_CLR: begin
                strb_d.output_buffer_load_clear = 1'b1;
                strb_d.input_buffer_delay_clear = 1'b1;
                strb_d.output_buffer_acc_clear  = (t_next == '0);
            end
            S_LOAD_W: begin
                strb_d.host_ready      = 1'b1;
                strb_d.host_sel_weight = 1'b1;
            end
            S_PRE_W: begin
                strb_d.weight_buffer_out_en = 1'b1;
                strb_d.write_weight_en      = 1'b1;
            end
            S_LOAD_A: strb_d.host_ready = 1'b1;
            S_STREAM: begin
                strb_d.input_buffer_out_en   = (cnt_next < CNT_W'(ARRAY_WIDTH));
                strb_d.output_buffer_load_en = (cnt_next >= CNT_W'(ARRAY_LAT));
            end
            S_ACC: strb_d.output_buffer_acc_enable = 1'b1;
            S_DRAIN: begin
                strb_d.output_buffer_out_en = 1'b1;
                strb_d.out_valid            = 1'b1;
                strb_d.relu_en              = (mode_q == MODE_RELU);
                strb_d.softmax_en           = (mode_q == MODE_SOFTMAX);
            end
            S_DONE:  strb_d.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            strb   <= '0;
            k_eff  <= KW'(1);
            mode_q <= MODE_RAW;
        end else begin
            state <= state_d;
            strb  <= strb_d;
            if ((state == S_IDLE) && start) begin
                k_eff  <= (k_tiles == '0) ? KW'(1) : k_tiles;
                mode_q <= mode;
            end
        end
    end

    // Load enables follow the live host_valid so a stalled beat is never captured.
    assign weight_buffer_load_en = strb.host_ready && strb.host_sel_weight && host_valid;
    assign input_buffer_load_en  = strb.host_ready && !strb.host_sel_weight && host_valid;

    assign host_ready               = strb.host_ready;
    assign host_sel_weight          = strb.host_sel_weight;
    assign input_buffer_out_en      = strb.input_buffer_out_en;
    assign input_buffer_delay_clear = strb.input_buffer_delay_clear;
    assign weight_buffer_out_en     = strb.weight_buffer_out_en;
    assign write_weight_en          = strb.write_weight_en;
    assign output_buffer_load_en    = strb.output_buffer_load_en;
    assign output_buffer_load_clear = strb.output_buffer_load_clear;
    assign output_buffer_acc_enable = strb.output_buffer_acc_enable;
    assign output_buffer_acc_clear  = strb.output_buffer_acc_clear;
    assign output_buffer_out_en     = strb.output_buffer_out_en;
    assign relu_en                  = strb.relu_en;
    assign softmax_en               = strb.softmax_en;
    assign out_valid                = strb.out_valid;
    assign busy                     = strb.busy;
    assign done                     = strb.done;
    assign fsm_state                = state;

endmodule

// File: tb/tb_accel_sequencer.sv
// Directed bench for accel_sequencer (N=4, ARRAY_LAT=11): cycle-accurate job
// traces are captured into logs, then checked against hand-derived timelines.
module tb_accel_sequencer;
    import accel_sequencer_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [KW-1:0] k_tiles;
    logic [1:0]    mode;
    logic          host_valid;
    logic host_ready, host_sel_weight, input_buffer_load_en, input_buffer_out_en;
    logic input_buffer_delay_clear, weight_buffer_load_en, weight_buffer_out_en;
    logic write_weight_en, output_buffer_load_en, output_buffer_load_clear;
    logic output_buffer_acc_enable, output_buffer_acc_clear, output_buffer_out_en;
    logic relu_en, softmax_en, out_valid, busy, done;
    logic [3:0] fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int B_DONE = 0, B_BUSY = 1, B_OVALID = 2, B_SOFTMAX = 3, B_RELU = 4;
    localparam int B_OBO = 5, B_OBAC = 6, B_OBAE = 7, B_OBLC = 8, B_OBL = 9;
    localparam int B_WWE = 10, B_WBO = 11, B_WBL = 12, B_IBDC = 13, B_IBO = 14;
    localparam int B_IBL = 15, B_SEL = 16, B_READY = 17;

    logic [17:0] snap;
    logic [3:0]  st_log [0:127];
    logic [17:0] sb_log [0:127];

    assign snap = {host_ready, host_sel_weight, input_buffer_load_en, input_buffer_out_en,
                   input_buffer_delay_clear, weight_buffer_load_en, weight_buffer_out_en,
                   write_weight_en, output_buffer_load_en, output_buffer_load_clear,
                   output_buffer_acc_enable, output_buffer_acc_clear, output_buffer_out_en,
                   relu_en, softmax_en, out_valid, busy, done};

    accel_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .k_tiles(k_tiles),
        .mode(mode), .host_valid(host_valid), .host_ready(host_ready),
        .host_sel_weight(host_sel_weight), .input_buffer_load_en(input_buffer_load_en),
        .input_buffer_out_en(input_buffer_out_en),
        .input_buffer_delay_clear(input_buffer_delay_clear),
        .weight_buffer_load_en(weight_buffer_load_en),
        .weight_buffer_out_en(weight_buffer_out_en), .write_weight_en(write_weight_en),
        .output_buffer_load_en(output_buffer_load_en),
        .output_buffer_load_clear(output_buffer_load_clear),
        .output_buffer_acc_enable(output_buffer_acc_enable),
        .output_buffer_acc_clear(output_buffer_acc_clear),
        .output_buffer_out_en(output_buffer_out_en), .relu_en(relu_en),
        .softmax_en(softmax_en), .out_valid(out_valid), .busy(busy), .done(done),
        .fsm_state(fsm_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    function automatic int count_bit(input int b, input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (sb_log[c][b]) n++;
        return n;
    endfunction

    function automatic int first_bit(input int b, input int hi);
        for (int c = 1; c <= hi; c++) if (sb_log[c][b]) return c;
        return -1;
    endfunction

    // Hand-derived state timeline for a K=1 job with host_valid held high.
    function automatic logic [3:0] exp_single(input int c);
        if (c == 1)  return S_CLR;
        if (c <= 5)  return S_LOAD_W;
        if (c <= 9)  return S_PRE_W;
        if (c <= 13) return S_LOAD_A;
        if (c <= 28) return S_STREAM;
        if (c == 29) return S_ACC;
        if (c <= 33) return S_DRAIN;
        if (c == 34) return S_DONE;
        return S_IDLE;
    endfunction

    // Driver: start is high in cycle 0; cycles 1..ncyc are logged. A zero
    // abort_at/rst_at/extra_start_at means that event is not applied.
    task automatic run_job(input logic [KW-1:0] k, input logic [1:0] m, input bit toggle_hv,
                           input int abort_at, input int rst_at, input int extra_start_at,
                           input int ncyc);
        @(posedge clk); #1;
        k_tiles = k; mode = m; start = 1'b1; abort = 1'b0; host_valid = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            start      = (c == extra_start_at) || (c == rst_at);
            abort      = (c == abort_at);
            rst        = (c == rst_at);
            host_valid = toggle_hv ? (c % 2 == 0) : 1'b1;
            #1;
            st_log[c] = fsm_state;
            sb_log[c] = snap;
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0; host_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b0; host_valid = 1'b1;
        k_tiles = '0; mode = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0; host_valid = 1'b0;
        #1;
        n_checks++;
        if (fsm_state !== S_IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, S_IDLE);
        end
        n_checks++;
        if (snap !== 18'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", snap);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #2;
        n_checks++;
        if (snap !== 18'd0) begin
            n_fail++; $display("FAIL idle_outputs: got %h expected 0", snap);
        end
    endtask

    task automatic test_single_job();
        int v;
        run_job(8'd1, 2'b00, 1'b0, 0, 0, 0, 40);
        for (int c = 1; c <= 40; c++) begin
            n_checks++;
            if (st_log[c] !== exp_single(c)) begin
                n_fail++;
                $display("FAIL single_state c=%0d: got %0d expected %0d", c, st_log[c], exp_single(c));
            end
        end
        v = first_bit(B_OBL, 40);
        n_checks++;
        if (v != 25 || count_bit(B_OBL, 1, 40) != 4) begin
            n_fail++; $display("FAIL single_obl: first %0d count %0d expected 25/4", v, count_bit(B_OBL, 1, 40));
        end
        v = first_bit(B_DONE, 40);
        n_checks++;
        if (v != 34 || count_bit(B_DONE, 1, 40) != 1) begin
            n_fail++; $display("FAIL single_done: first %0d expected 34", v);
        end
        v = first_bit(B_OBAC, 40);
        n_checks++;
        if (v != 1 || count_bit(B_OBAC, 1, 40) != 1 || !sb_log[1][B_OBLC] || !sb_log[1][B_IBDC]) begin
            n_fail++; $display("FAIL single_clr: acc_clear first %0d snap %h expected 1", v, sb_log[1]);
        end
        v = first_bit(B_WBL, 40);
        n_checks++;
        if (v != 2 || count_bit(B_WBL, 1, 40) != 4 || count_bit(B_IBL, 10, 13) != 4) begin
            n_fail++; $display("FAIL single_loads: wbl first %0d expected 2", v);
        end
        v = first_bit(B_IBO, 40);
        n_checks++;
        if (v != 14 || count_bit(B_IBO, 1, 40) != 4 || count_bit(B_WWE, 6, 9) != 4) begin
            n_fail++; $display("FAIL single_stream: ibo first %0d expected 14", v);
        end
        n_checks++;
        if (count_bit(B_BUSY, 1, 40) != 34 || count_bit(B_RELU, 1, 40) != 0 || count_bit(B_OVALID, 30, 33) != 4) begin
            n_fail++; $display("FAIL single_misc: busy %0d expected 34", count_bit(B_BUSY, 1, 40));
        end
    endtask

    task automatic test_k3();
        int v;
        run_job(8'd3, 2'b00, 1'b0, 0, 0, 0, 100);
        n_checks++;
        if (count_bit(B_OBAC, 1, 100) != 1 || !sb_log[1][B_OBAC]) begin
            n_fail++; $display("FAIL k3_acc_clear: count %0d expected 1", count_bit(B_OBAC, 1, 100));
        end
        n_checks++;
        if (count_bit(B_OBAE, 1, 100) != 3) begin
            n_fail++; $display("FAIL k3_acc_enable: count %0d expected 3", count_bit(B_OBAE, 1, 100));
        end
        // Each extra tile repeats CLR..ACC: 1 + 4 + 4 + 4 + 15 + 1 = 29 cycles.
        v = first_bit(B_DONE, 100);
        n_checks++;
        if (v != 92 || count_bit(B_DONE, 1, 100) != 1) begin
            n_fail++; $display("FAIL k3_done: cycle %0d expected 92", v);
        end
        n_checks++;
        if (count_bit(B_OBLC, 1, 100) != 3 || count_bit(B_OBL, 1, 100) != 12) begin
            n_fail++; $display("FAIL k3_clr_count: got %0d expected 3", count_bit(B_OBLC, 1, 100));
        end
    endtask

    task automatic test_k0();
        run_job(8'd0, 2'b00, 1'b0, 0, 0, 0, 40);
        n_checks++;
        if (first_bit(B_DONE, 40) != 34 || count_bit(B_OBAE, 1, 40) != 1) begin
            n_fail++; $display("FAIL k0_as_one: done %0d expected 34", first_bit(B_DONE, 40));
        end
    endtask

    task automatic test_stall();
        run_job(8'd1, 2'b00, 1'b1, 0, 0, 0, 45);
        n_checks++;
        if (count_bit(B_WBL, 1, 45) != 4 || sb_log[3][B_WBL] || !sb_log[8][B_WBL]) begin
            n_fail++; $display("FAIL stall_wbl: count %0d expected 4", count_bit(B_WBL, 1, 45));
        end
        n_checks++;
        if (st_log[8] !== S_LOAD_W || st_log[9] !== S_PRE_W) begin
            n_fail++; $display("FAIL stall_pre_w: c8 %0d c9 %0d expected %0d/%0d", st_log[8], st_log[9], S_LOAD_W, S_PRE_W);
        end
        n_checks++;
        if (first_bit(B_DONE, 45) != 41 || count_bit(B_IBL, 1, 45) != 4) begin
            n_fail++; $display("FAIL stall_done: cycle %0d expected 41", first_bit(B_DONE, 45));
        end
    endtask

    task automatic test_modes();
        for (int m = 1; m <= 3; m++) begin
            run_job(8'd1, 2'(m), 1'b0, 0, 0, 0, 36);
            n_checks++;
            if (count_bit(B_RELU, 1, 36) != ((m == 1) ? 4 : 0) || (m == 1 && !sb_log[30][B_RELU])) begin
                n_fail++; $display("FAIL mode%0d_relu: count %0d", m, count_bit(B_RELU, 1, 36));
            end
            n_checks++;
            if (count_bit(B_SOFTMAX, 1, 36) != ((m == 2) ? 4 : 0) || (m == 2 && !sb_log[33][B_SOFTMAX])) begin
                n_fail++; $display("FAIL mode%0d_softmax: count %0d", m, count_bit(B_SOFTMAX, 1, 36));
            end
        end
    endtask

    task automatic test_abort();
        run_job(8'd1, 2'b00, 1'b0, 18, 0, 0, 40);
        n_checks++;
        if (st_log[18] !== S_STREAM || st_log[19] !== S_IDLE) begin
            n_fail++; $display("FAIL abort_state: c18 %0d c19 %0d expected %0d/%0d", st_log[18], st_log[19], S_STREAM, S_IDLE);
        end
        n_checks++;
        if (sb_log[19] !== 18'd0 || count_bit(B_BUSY, 19, 40) != 0) begin
            n_fail++; $display("FAIL abort_outputs: got %h expected 0", sb_log[19]);
        end
        n_checks++;
        if (count_bit(B_DONE, 1, 40) != 0) begin
            n_fail++; $display("FAIL abort_no_done: count %0d expected 0", count_bit(B_DONE, 1, 40));
        end
        run_job(8'd1, 2'b00, 1'b0, 0, 0, 0, 40);
        n_checks++;
        if (first_bit(B_DONE, 40) != 34 || first_bit(B_OBL, 40) != 25) begin
            n_fail++; $display("FAIL abort_restart: done %0d expected 34", first_bit(B_DONE, 40));
        end
    endtask

    task automatic test_reset_mid_job();
        run_job(8'd1, 2'b00, 1'b0, 0, 7, 0, 40);
        n_checks++;
        if (st_log[7] !== S_PRE_W || st_log[8] !== S_IDLE) begin
            n_fail++; $display("FAIL rst_mid_state: c7 %0d c8 %0d expected %0d/%0d", st_log[7], st_log[8], S_PRE_W, S_IDLE);
        end
        n_checks++;
        if (sb_log[8] !== 18'd0 || count_bit(B_BUSY, 8, 40) != 0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got %h expected 0", sb_log[8]);
        end
    endtask

    task automatic test_start_while_busy();
        run_job(8'd1, 2'b00, 1'b0, 0, 0, 12, 40);
        for (int c = 10; c <= 36; c++) begin
            n_checks++;
            if (st_log[c] !== exp_single(c)) begin
                n_fail++;
                $display("FAIL busy_start_state c=%0d: got %0d expected %0d", c, st_log[c], exp_single(c));
            end
        end
        n_checks++;
        if (count_bit(B_DONE, 1, 40) != 1 || first_bit(B_DONE, 40) != 34) begin
            n_fail++; $display("FAIL busy_start_done: cycle %0d expected 34", first_bit(B_DONE, 40));
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_k3();
        test_k0();
        test_stall();
        test_modes();
        test_abort();
        test_reset_mid_job();
        test_start_while_busy();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
